// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller.
package serial_adder_ctrl_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/serial_adder_ctrl_fa_cell.sv
// Combinational 1-bit full adder shared by the serial datapath.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic co
);

    // Sum and carry of one bit position.
    always_comb begin
        s  = a ^ b ^ cin;
        co = (a & b) | ((a ^ b) & cin);
    end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, LSB first, one bit per cycle.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic               carry;
    logic               cell_s;
    logic               cell_co;
    logic               last_bit;

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    fa_cell u_fa (
        .a   (a_sr[0]),
        .b   (b_sr[0]),
        .cin (carry),
        .s   (cell_s),
        .co  (cell_co)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; start is only honoured in IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath and registered status flags decoded from the upcoming state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= '0;
            a_sr  <= '0;
            b_sr  <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            busy <= (state_next == RUN);
            done <= (state_next == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    carry <= cell_co;
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    sum   <= {cell_s, sum[WIDTH-1:1]};
                    if (last_bit) begin
                        cnt  <= '0;
                        cout <= cell_co;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl at WIDTH=8 and WIDTH=13.
module tb_serial_adder_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        start8, cin8, busy8, done8, cout8;
    logic [7:0]  a8, b8, sum8;
    logic        start13, cin13, busy13, done13, cout13;
    logic [12:0] a13, b13, sum13;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [13:0] sb_q[$];

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder_ctrl #(.WIDTH(13)) dut13 (
        .clk(clk), .rst_n(rst_n), .start(start13), .a(a13), .b(b13), .cin(cin13),
        .busy(busy13), .done(done13), .sum(sum13), .cout(cout13)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [13:0] ref_sum(input int sel, input logic [12:0] a,
                                            input logic [12:0] b, input logic ci);
        if (sel == 0)
            return 14'({1'b0, a[7:0]} + {1'b0, b[7:0]} + 9'(ci));
        return 14'({1'b0, a} + {1'b0, b} + 14'(ci));
    endfunction

    // Set up operands and raise start on the selected DUT.
    task automatic drive(input int sel, input logic [12:0] a, input logic [12:0] b,
                         input logic ci, input logic st);
        if (sel == 0) begin
            a8 = a[7:0]; b8 = b[7:0]; cin8 = ci; start8 = st;
        end else begin
            a13 = a; b13 = b; cin13 = ci; start13 = st;
        end
    endtask

    // Called #1 after an accept edge: track busy until done, then score the result.
    task automatic wait_done(input int sel);
        int          w;
        bit          seen;
        logic        bz, dn;
        logic [13:0] obs, exp;
        w    = (sel == 0) ? 8 : 13;
        seen = 1'b0;
        for (int k = 1; k <= w + 4 && !seen; k++) begin
            @(negedge clk);
            bz  = (sel == 0) ? busy8 : busy13;
            dn  = (sel == 0) ? done8 : done13;
            obs = (sel == 0) ? {5'b0, cout8, sum8} : {cout13, sum13};
            if (dn === 1'b1) begin
                seen = 1'b1;
                check("latency", k, w + 1);
                check("busy_during_done", 32'(bz), 0);
                exp = (sb_q.size() > 0) ? sb_q.pop_front() : 14'h3fff;
                check("result", 32'(obs), 32'(exp));
            end else if (k <= w) begin
                check("busy_in_run", 32'(bz), 1);
            end
        end
        check("done_seen", 32'(seen), 1);
    endtask

    // One complete operation with a single-cycle start pulse.
    task automatic op(input int sel, input logic [12:0] a, input logic [12:0] b, input logic ci);
        @(posedge clk); #1;
        drive(sel, a, b, ci, 1'b1);
        @(posedge clk); #1;
        sb_q.push_back(ref_sum(sel, a, b, ci));
        drive(sel, 13'h0, 13'h0, 1'b0, 1'b0);
        wait_done(sel);
    endtask

    // start held high across two operations; operands change right after the first accept.
    task automatic held_start(input logic [7:0] a1, input logic [7:0] b1,
                              input logic [7:0] a2, input logic [7:0] b2);
        @(posedge clk); #1;
        drive(0, 13'(a1), 13'(b1), 1'b0, 1'b1);
        @(posedge clk); #1;
        sb_q.push_back(ref_sum(0, 13'(a1), 13'(b1), 1'b0));
        drive(0, 13'(a2), 13'(b2), 1'b0, 1'b1);
        wait_done(0);
        @(negedge clk);
        check("idle_gap_busy", 32'(busy8), 0);
        check("idle_gap_done", 32'(done8), 0);
        @(posedge clk); #1;
        sb_q.push_back(ref_sum(0, 13'(a2), 13'(b2), 1'b0));
        drive(0, 13'h0, 13'h0, 1'b0, 1'b0);
        wait_done(0);
    endtask

    initial begin
        int done_cnt;
        rst_n = 1'b0;
        drive(0, 13'h0, 13'h0, 1'b0, 1'b0);
        drive(1, 13'h0, 13'h0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy8", 32'(busy8), 0);
        check("rst_done8", 32'(done8), 0);
        check("rst_sum8", 32'(sum8), 0);
        check("rst_cout8", 32'(cout8), 0);
        check("rst_busy13", 32'(busy13), 0);
        check("rst_sum13", 32'(sum13), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Basic add with result hold through T+20.
        op(0, 13'h5A, 13'h3C, 1'b0);
        for (int k = 10; k <= 20; k++) begin
            @(negedge clk);
            check("hold_sum", 32'(sum8), 32'h96);
            check("hold_cout", 32'(cout8), 0);
            check("hold_done", 32'(done8), 0);
        end

        // Carry boundary cases.
        op(0, 13'hFF, 13'h01, 1'b0);
        op(0, 13'hFF, 13'hFF, 1'b1);
        op(0, 13'h00, 13'h00, 1'b1);

        // Operand changes during RUN are ignored; start held is not queued.
        held_start(8'h10, 8'h20, 8'hAA, 8'h55);
        // Back-to-back with continuous start.
        held_start(8'h5A, 8'h3C, 8'hFF, 8'h01);

        // Reset at T+4 of a run discards the operation.
        @(posedge clk); #1;
        drive(0, 13'h77, 13'h11, 1'b1, 1'b1);
        @(posedge clk); #1;
        drive(0, 13'h0, 13'h0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_busy", 32'(busy8), 0);
        check("midrst_done", 32'(done8), 0);
        check("midrst_sum", 32'(sum8), 0);
        check("midrst_cout", 32'(cout8), 0);
        done_cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8 === 1'b1) done_cnt++;
        end
        check("midrst_no_done", 32'(done_cnt), 0);
        op(0, 13'h5A, 13'h3C, 1'b1);

        // Random operands against the reference sum.
        for (int i = 0; i < 1000; i++)
            op(0, 13'($urandom_range(0, 255)), 13'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        op(1, 13'h1FFF, 13'h0001, 1'b0);
        op(1, 13'h1FFF, 13'h1FFF, 1'b1);
        for (int i = 0; i < 1000; i++)
            op(1, 13'($urandom_range(0, 8191)), 13'($urandom_range(0, 8191)), 1'($urandom_range(0, 1)));

        check("scoreboard_empty", 32'(sb_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
